// File: rtl/ram_sp_init.sv
// ram_sp_init
//   Single-port synchronous RAM with chip select and separate read and write
//   strobes. After every reset a clear sequencer writes INIT_VAL to every
//   location. Accesses are ignored until the clear is complete.
//   Reads have a registered data output, and dout_valid pulses when the data
//   is fresh. Asserting rd and wr together is reported on err and is not
//   performed.
//
// Parameters
//   DATA_W   : word width in bits
//   ADDR_W   : address width; depth is 2**ADDR_W words
//   INIT_VAL : value the clear sequencer writes to every location
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   cs         : chip select; without it nothing happens
//   rd, wr     : read / write strobes (both together = collision)
//   addr       : word address
//   din        : write data
//   dout       : registered read data; it holds the last read value
//   dout_valid : one-cycle pulse when dout carries fresh read data
//   init_busy  : high while the clear sequencer runs
//   err        : one-cycle pulse after a collision (cs & rd & wr)
//
// Optional build macro
//   RAM_OUT_REG_EN : adds a second output register. Read latency becomes
//                    2 cycles, and dout_valid follows it. err timing does
//                    not change.
module ram_sp_init #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 10,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              init_busy,
  output logic              err
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;

  logic              idle;
  logic              rd_acc;
  logic              wr_acc;
  logic              col;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic              vld_p0;
  logic [DATA_W-1:0] dout_p0;
  logic              err_p0;

  // Host access qualification: nothing is accepted until the clear is done.
  always_comb begin
    idle   = (state == ST_IDLE);
    rd_acc = idle & cs & rd & ~wr;
    wr_acc = idle & cs & wr & ~rd;
    col    = idle & cs & rd & wr;
  end

  // Single write port, shared between the clear sequencer and the host.
  // While rst_n is held low the sequencer keeps writing INIT_VAL to
  // location 0. This is harmless because location 0 is cleared again
  // after release.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = ptr;
    mem_wd = INIT_VAL;
    if (!idle) begin
      mem_we = 1'b1;
    end else if (wr_acc) begin
      mem_we = 1'b1;
      mem_wa = addr;
      mem_wd = din;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Clear sequencer. The pointer stops at the last location so the clear
  // can never wrap into a second pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else if (state == ST_INIT) begin
      if (ptr == PTR_LAST) begin
        state <= ST_IDLE;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  assign init_busy = (state == ST_INIT);

  // Stage p0: array read register, read-valid and collision flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      err_p0  <= 1'b0;
      dout_p0 <= '0;
    end else begin
      vld_p0 <= rd_acc;
      err_p0 <= col;
      if (rd_acc) begin
        dout_p0 <= mem[addr];
      end
    end
  end

  assign err = err_p0;

`ifdef RAM_OUT_REG_EN
  logic              vld_p1;
  logic [DATA_W-1:0] dout_p1;

  // Stage p1: optional output register; it only captures fresh read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      dout_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        dout_p1 <= dout_p0;
      end
    end
  end

  assign dout       = dout_p1;
  assign dout_valid = vld_p1;
`else
  assign dout       = dout_p0;
  assign dout_valid = vld_p0;
`endif

endmodule

// File: tb/tb_ram_sp_init.sv
module tb_ram_sp_init;

`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int INIT_CYC = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [9:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       init_busy;
  logic       err;

  int total = 0;
  int bad   = 0;

  ram_sp_init #(.DATA_W(8), .ADDR_W(10), .INIT_VAL(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .rd         (rd),
    .wr         (wr),
    .addr       (addr),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .init_busy  (init_busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #600_000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  // Counts the edges after release until init_busy falls. An injected write
  // at edge 5 must be ignored.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (1) begin
      if (n == 4) begin
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = 10'h020; din = 8'h77;
      end
      tick();
      n++;
      if (n == 5) begin
        chk({tag, "_busy_err"}, err, 1'b0);
        chk({tag, "_busy_vld"}, dout_valid, 1'b0);
        idle_bus();
      end
      if (!init_busy || n >= 3000) break;
    end
    chk({tag, "_len"}, n, INIT_CYC);
  endtask

  task automatic do_write(input logic [9:0] a, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; din = d;
    tick();
    idle_bus();
  endtask

  task automatic do_read(input logic [9:0] a, input logic [7:0] exp, input string tag);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    tick();
    idle_bus();
    repeat (LAT - 1) tick();
    chk({tag, "_vld"}, dout_valid, 1'b1);
    chk({tag, "_dat"}, dout, exp);
  endtask

  initial begin
    logic [9:0] b2b_a [3];
    logic [7:0] b2b_d [3];
    int         k;

    // Reset state
    #12;
    chk("rst_dout", dout, 8'h00);
    chk("rst_vld", dout_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", init_busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init1");

    // Cleared contents, including the ignored write at 0x020
    do_read(10'h000, 8'h00, "clr_000");
    do_read(10'h155, 8'h00, "clr_155");
    do_read(10'h3FF, 8'h00, "clr_3ff");
    do_read(10'h020, 8'h00, "clr_020");

    // Write, then read the same address on the next edge
    do_write(10'h003, 8'hA5);
    chk("wr_no_vld", dout_valid, 1'b0);
    do_read(10'h003, 8'hA5, "raw_003");
    tick();
    chk("vld_drop", dout_valid, 1'b0);

    // Collision
    do_write(10'h010, 8'h3C);
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 10'h010; din = 8'hFF;
    tick();
    idle_bus();
    chk("col_err", err, 1'b1);
    chk("col_vld", dout_valid, 1'b0);
    chk("col_dout", dout, 8'hA5);
    tick();
    chk("col_err_drop", err, 1'b0);
    chk("col_vld2", dout_valid, 1'b0);
    do_read(10'h010, 8'h3C, "col_rd");

    // cs low: no access
    cs = 1'b0; rd = 1'b1; wr = 1'b0; addr = 10'h010;
    repeat (LAT + 1) begin
      tick();
      chk("nocs_vld", dout_valid, 1'b0);
      chk("nocs_err", err, 1'b0);
    end
    cs = 1'b0; rd = 1'b0; wr = 1'b1; din = 8'h99;
    tick();
    idle_bus();
    do_read(10'h010, 8'h3C, "nocs_wr");

    // Reset, then reset again 500 cycles into the clear
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_dout", dout, 8'h00);
    chk("rst2_busy", init_busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    chk("mid_busy", init_busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", init_busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init2");

    for (int a = 0; a < 1024; a++) begin
      do_read(a[9:0], 8'h00, "clr_all");
    end

    // Boundary addresses and back-to-back reads
    do_write(10'h3FF, 8'h81);
    do_write(10'h000, 8'h42);
    do_read(10'h3FF, 8'h81, "bnd_3ff");
    do_read(10'h000, 8'h42, "bnd_000");

    b2b_a[0] = 10'h3FF; b2b_d[0] = 8'h81;
    b2b_a[1] = 10'h000; b2b_d[1] = 8'h42;
    b2b_a[2] = 10'h3FF; b2b_d[2] = 8'h81;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = b2b_a[c];
      end else begin
        idle_bus();
      end
      tick();
      k = c - (LAT - 1);
      if (k >= 0 && k < 3) begin
        chk("b2b_vld", dout_valid, 1'b1);
        chk("b2b_dat", dout, b2b_d[k]);
      end else begin
        chk("b2b_vld_lo", dout_valid, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
